// File: rtl/inv_key_expansion.sv
// Reverse AES-128 key scheduler: takes the round-10 key and streams round
// keys 10 down to 0 over a valid/ready handshake, one key per transfer.

// Forward AES S-box computed as GF(2^8) inverse followed by the affine map.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse (and maps 0 to 0), then the affine step
  always_comb begin
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = in_byte;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

module inv_key_expansion #(
  parameter int KEY_LEN       = 128,
  parameter int NUMS_OF_ROUND = 10,
  parameter int WORD_LEN      = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [KEY_LEN-1:0] last_key,
  input  logic               valid_in,
  output logic               ready_in,
  output logic [KEY_LEN-1:0] round_key,
  output logic [3:0]         round_idx,
  output logic               valid_out,
  input  logic               ready_out,
  output logic               last_out,
  output logic               busy
);

  localparam int NUM_WORDS = KEY_LEN / WORD_LEN;
  localparam int NUM_BYTES = WORD_LEN / 8;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t             state_reg, state_next;
  logic [KEY_LEN-1:0] key_reg, key_next;
  logic [3:0]         idx_reg, idx_next;

  logic [WORD_LEN-1:0] w [NUM_WORDS];
  logic [WORD_LEN-1:0] p3, rot_word, sub_word, rcon_word;
  logic [KEY_LEN-1:0]  prev_key;

  genvar gi;

  // Split the current key into words, w[0] being the most significant
  generate
    for (gi = 0; gi < NUM_WORDS; gi++) begin : g_word
      assign w[gi] = key_reg[KEY_LEN-1-gi*WORD_LEN -: WORD_LEN];
    end
  endgenerate

  // Undo the forward recurrence: later words come straight from XORs,
  // w0 needs the g() function applied to the recovered previous w3.
  assign p3       = w[3] ^ w[2];
  assign rot_word = {p3[WORD_LEN-9:0], p3[WORD_LEN-1:WORD_LEN-8]};

  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_sbox
      aes_sbox u_sbox (
        .in_byte (rot_word[gi*8 +: 8]),
        .out_byte(sub_word[gi*8 +: 8])
      );
    end
  endgenerate

  // Round constant for the key being undone (round r uses table entry r-1)
  always_comb begin
    rcon_word = '0;
    case (idx_reg)
      4'd1:    rcon_word[WORD_LEN-1 -: 8] = 8'h01;
      4'd2:    rcon_word[WORD_LEN-1 -: 8] = 8'h02;
      4'd3:    rcon_word[WORD_LEN-1 -: 8] = 8'h04;
      4'd4:    rcon_word[WORD_LEN-1 -: 8] = 8'h08;
      4'd5:    rcon_word[WORD_LEN-1 -: 8] = 8'h10;
      4'd6:    rcon_word[WORD_LEN-1 -: 8] = 8'h20;
      4'd7:    rcon_word[WORD_LEN-1 -: 8] = 8'h40;
      4'd8:    rcon_word[WORD_LEN-1 -: 8] = 8'h80;
      4'd9:    rcon_word[WORD_LEN-1 -: 8] = 8'h1b;
      4'd10:   rcon_word[WORD_LEN-1 -: 8] = 8'h36;
      default: rcon_word = '0;
    endcase
  end

  assign prev_key = {w[0] ^ sub_word ^ rcon_word, w[1] ^ w[0], w[2] ^ w[1], p3};

  // State and key/index registers; reset aborts any sequence in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      key_reg   <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      key_reg   <= key_next;
      idx_reg   <= idx_next;
    end
  end

  // Next state: load on accept, step back one round per output transfer
  always_comb begin
    state_next = state_reg;
    key_next   = key_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        if (valid_in) begin
          key_next   = last_key;
          idx_next   = 4'(NUMS_OF_ROUND);
          state_next = EMIT;
        end
      end
      EMIT: begin
        if (ready_out) begin
          if (idx_reg == 4'd0) begin
            state_next = IDLE;
          end else begin
            key_next = prev_key;
            idx_next = idx_reg - 4'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are pure functions of the registered state
  always_comb begin
    ready_in  = (state_reg == IDLE);
    valid_out = (state_reg == EMIT);
    busy      = (state_reg == EMIT);
    last_out  = (state_reg == EMIT) && (idx_reg == 4'd0);
    round_key = key_reg;
    round_idx = idx_reg;
  end

endmodule

// File: tb/tb_inv_key_expansion.sv
// Scoreboard bench for inv_key_expansion: drivers push expected keys,
// a negedge monitor pops and compares on each output transfer.
module tb_inv_key_expansion;

  logic         clk;
  logic         reset;
  logic [127:0] last_key;
  logic         valid_in;
  logic         ready_in;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         valid_out;
  logic         ready_out;
  logic         last_out;
  logic         busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [127:0] key;
    logic [3:0]   idx;
  } exp_t;

  exp_t exp_q[$];

  // FIPS-197 A.1 round keys, index = round number
  logic [127:0] fips_keys [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  logic [7:0] sbox_tab [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  logic [31:0] rcon_tab [1:10] = '{
    32'h01000000, 32'h02000000, 32'h04000000, 32'h08000000, 32'h10000000,
    32'h20000000, 32'h40000000, 32'h80000000, 32'h1b000000, 32'h36000000
  };

  logic [127:0] zero_keys [0:10];

  inv_key_expansion dut (
    .clk      (clk),
    .reset    (reset),
    .last_key (last_key),
    .valid_in (valid_in),
    .ready_in (ready_in),
    .round_key(round_key),
    .round_idx(round_idx),
    .valid_out(valid_out),
    .ready_out(ready_out),
    .last_out (last_out),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Table-driven reverse step used only for the all-zero key sequence
  function automatic logic [127:0] model_prev(input logic [127:0] k, input int r);
    logic [31:0] w0, w1, w2, w3, t, s;
    {w0, w1, w2, w3} = k;
    t = w3 ^ w2;
    t = {t[23:0], t[31:24]};
    s = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
    return {w0 ^ s ^ rcon_tab[r], w0 ^ w1, w1 ^ w2, w2 ^ w3};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic push_fips();
    for (int r = 10; r >= 0; r--) exp_q.push_back('{key: fips_keys[r], idx: 4'(r)});
  endtask

  task automatic push_zero();
    for (int r = 10; r >= 0; r--) exp_q.push_back('{key: zero_keys[r], idx: 4'(r)});
  endtask

  // Pulse valid_in for one cycle and confirm the first key arrives one cycle later
  task automatic start_seq(input logic [127:0] k);
    @(posedge clk); #1;
    last_key = k;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    last_key = '0;
    @(negedge clk);
    check("latency_valid", valid_out, 1);
    check("latency_idx", round_idx, 10);
  endtask

  task automatic wait_done(input int bound);
    logic done;
    done = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (valid_out && ready_out && last_out) begin
        done = 1'b1;
        break;
      end
    end
    check("seq_done", done, 1);
  endtask

  task automatic check_idle();
    @(negedge clk);
    check("idle_ready_in", ready_in, 1);
    check("idle_valid_out", valid_out, 0);
  endtask

  // Monitor: compare every transfer with the scoreboard and check stall stability
  initial begin
    exp_t         e;
    logic         prev_stall;
    logic [127:0] prev_key;
    logic [3:0]   prev_idx;
    prev_stall = 1'b0;
    prev_key   = '0;
    prev_idx   = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", valid_out, 1);
          check("stall_key", round_key, prev_key);
          check("stall_idx", round_idx, prev_idx);
        end
        if (valid_out && ready_out) begin
          if (exp_q.size() == 0) begin
            check("unexpected_key", round_idx, 4'hf);
          end else begin
            e = exp_q.pop_front();
            check("key", round_key, e.key);
            check("idx", round_idx, e.idx);
            check("last_out", last_out, (e.idx == 4'd0));
            $display("xfer idx=%0d key=%h last=%0b", round_idx, round_key, last_out);
          end
        end
        prev_stall = valid_out && !ready_out;
        prev_key   = round_key;
        prev_idx   = round_idx;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int gap;
    int stall;
    logic done;

    zero_keys[10] = '0;
    for (int r = 10; r >= 1; r--) zero_keys[r-1] = model_prev(zero_keys[r], r);

    reset     = 1'b1;
    valid_in  = 1'b0;
    last_key  = '0;
    ready_out = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("rst_ready_in", ready_in, 1);
    check("rst_valid_out", valid_out, 0);
    check("rst_last_out", last_out, 0);
    check("rst_busy", busy, 0);
    check("rst_round_key", round_key, 0);
    check("rst_round_idx", round_idx, 0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;

    // Test 1: ready_out high, 11 keys on consecutive cycles
    push_fips();
    start_seq(fips_keys[10]);
    check("busy_emit", busy, 1);
    n = 1;
    while (!last_out && n < 30) begin
      @(negedge clk);
      if (!valid_out) break;
      n++;
    end
    check("consecutive_count", n, 11);
    check_idle();

    // Test 2: random backpressure with a 20-cycle stall at idx 5
    push_fips();
    start_seq(fips_keys[10]);
    stall = 0;
    done  = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk); #1;
      if (valid_out && round_idx == 4'd5 && stall < 20) begin
        ready_out = 1'b0;
        stall++;
      end else begin
        ready_out = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (valid_out && ready_out && last_out) begin
        done = 1'b1;
        break;
      end
    end
    check("bp_done", done, 1);
    @(posedge clk); #1;
    ready_out = 1'b1;
    check_idle();

    // Test 3: valid_in with another key while busy is ignored
    push_fips();
    start_seq(fips_keys[10]);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      valid_in = 1'b1;
      last_key = 128'h0123456789abcdef0123456789abcdef;
      @(negedge clk);
      check("busy_ready_in", ready_in, 0);
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
    last_key = '0;
    wait_done(20);
    check_idle();

    // Test 4: reset at idx 6 aborts, then a fresh sequence starts at idx 10
    push_fips();
    start_seq(fips_keys[10]);
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid_out && round_idx == 4'd6) begin
        done = 1'b1;
        break;
      end
    end
    check("reach_idx6", done, 1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_ready_in", ready_in, 1);
    check("mid_rst_valid_out", valid_out, 0);
    check("mid_rst_last_out", last_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_round_key", round_key, 0);
    check("mid_rst_round_idx", round_idx, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    check("no_resume_valid", valid_out, 0);
    check("no_resume_ready", ready_in, 1);
    push_fips();
    start_seq(fips_keys[10]);
    wait_done(20);
    check_idle();

    // Test 5: valid_in held high, exactly one idle cycle between sequences
    push_fips();
    push_fips();
    @(posedge clk); #1;
    valid_in = 1'b1;
    last_key = fips_keys[10];
    wait_done(20);
    gap = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (valid_out) break;
      gap++;
    end
    check("b2b_gap", gap, 1);
    check("b2b_restart_idx", round_idx, 10);
    @(posedge clk); #1;
    valid_in = 1'b0;
    last_key = '0;
    wait_done(20);
    check_idle();

    // Test 6: all-zero round-10 key against the table-driven model
    push_zero();
    start_seq('0);
    wait_done(20);
    check_idle();

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
